mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO with a valid/ready handshake, and supports a pipeline flush that aborts an in-flight operation.
- Width and multiply latency are parametrised; divide is iterative radix-2.

Parameters:
- DATA_WIDTH, 32, operand/HI/LO width.
- MUL_LATENCY, 4, cycles from accept to HI/LO update for MULT/MULTU (>=1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request this cycle
- md_ctl  input  3  MdCtl opcode
- op1  input  DATA_WIDTH  rs value (dividend/multiplicand)
- op2  input  DATA_WIDTH  rt value (divisor/multiplier)
- flush  input  1  abort in-flight op, drop the current request
- out_valid  output  1  result valid (MFHI/MFLO), one-cycle pulse
- result  output  DATA_WIDTH  MFHI/MFLO data
- done  output  1  one-cycle pulse when a MULT/DIV/MT* commits HI/LO
- hi  output  DATA_WIDTH  current HI
- lo  output  DATA_WIDTH  current LO

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; hi=lo=0; result=0; out_valid=0; done=0; in_ready=1 once released. Reset mid-operation discards the operation.
- States and transitions:
  - IDLE, MUL_BUSY, DIV_BUSY.
  - in_ready = (state==IDLE).
  - Accept = in_valid & in_ready & ~flush.
- MFHI/MFLO accepted at edge E0: result and out_valid=1 during the cycle after E0. Value is HI/LO as of E0. State stays IDLE.
- MTHI/MTLO accepted at E0: HI (or LO) = op1 after E0; done=1 the following cycle.
- MULT/MULTU accepted at E0:
  - Operands latched; counter loaded with MUL_LATENCY-1; state MUL_BUSY.
  - The 2*DATA_WIDTH product {HI,LO} is written at edge E_L (L=MUL_LATENCY).
  - done=1 and state IDLE during cycle L; a new request may be accepted in that cycle.
  - MULT is signed; MULTU is unsigned.
- DIV/DIVU accepted at E0:
  - Operands latched as magnitudes plus sign flags (DIVU has flags 0); state DIV_BUSY.
  - md_divider runs DATA_WIDTH restoring iterations, then one sign-fix cycle.
  - LO=quotient and HI=remainder are written at edge E_(DATA_WIDTH+1); done pulses the next cycle.
  - Sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = op1. Takes the same cycle count as a normal divide.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- flush:
  - When busy: counter cleared, state IDLE next cycle, HI/LO unchanged, done not asserted.
  - When IDLE: the request is ignored.
  - flush in the same cycle as the completion edge: the completion wins (HI/LO are written).
- Back-to-back operation: a request presented while busy stalls (in_ready=0). The upstream holds md_ctl/op1/op2 stable until accepted.
- Illegal md_ctl in SIMULATION: $display warning; treated as a NOP (no state change, no pulses).

Decomposition:
- mips_core_pkg additions:
  - MdCtl enum: MDCTL_NOP, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - MdState enum (IDLE, MUL_BUSY, DIV_BUSY).
- Multiplier: behavioural product registered through a MUL_LATENCY-deep shift of valid, or counter plus a final register; synthesis retimes it.
- Sub-module md_divider (parametrised DATA_WIDTH):
  - Ports: start, unsigned dividend/divisor in; busy, quotient/remainder out.
  - Also takes the same clk/rst_n and an abort input.

Test Plan:
- MULT op1=-3 op2=7 -> after 4 cycles done=1, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. MULTU same operands -> hi=32'h00000006, lo=32'hFFFFFFEB.
- DIV op1=-7 op2=2 -> done 33 cycles after accept, lo=-3, hi=-1. DIVU 100/7 -> lo=14, hi=2.
- DIV op1=5 op2=0 -> lo=32'hFFFFFFFF, hi=5. DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
- MTHI 0x1234, then MFHI back-to-back -> out_valid next cycle with result=0x1234. MFLO issued while DIV is busy -> in_ready=0 until done; the returned value is the new LO.
- DIV started, flush asserted 10 cycles later -> IDLE next cycle, no done, hi/lo retain their prior values. A following MULTU 3*4 -> lo=12.
- rst_n pulsed low during MUL_BUSY -> hi=lo=0 and in_ready=1 immediately after release; no stale done pulse.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: multiply/divide opcodes and the mult/div unit's state encoding.
package mips_core_pkg;

    // The 3-bit md_ctl port carries exactly the eight real operations.
    // MDCTL_NOP sits outside that range and is only the internal "no operation" code.
    typedef enum logic [3:0] {
        MULT      = 4'd0,
        MULTU     = 4'd1,
        DIV       = 4'd2,
        DIVU      = 4'd3,
        MFHI      = 4'd4,
        MFLO      = 4'd5,
        MTHI      = 4'd6,
        MTLO      = 4'd7,
        MDCTL_NOP = 4'd8
    } md_ctl_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } md_state_e;

    localparam int unsigned MD_CTL_W = 3;

    // Map a raw port opcode onto the operation enum.
    function automatic md_ctl_e md_decode(input logic [MD_CTL_W-1:0] code);
        return md_ctl_e'({1'b0, code});
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle, DATA_WIDTH cycles from start until busy drops.
module md_divider #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    logic [DATA_WIDTH:0]   trial;
    logic [DATA_WIDTH:0]   diff;
    logic                  fits;

    // Quotient shifts in from the bottom while the dividend shifts out of the top.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        trial  = {rem_q, quo_q[DATA_WIDTH-1]};
        diff   = trial - {1'b0, dvs_q};
        fits   = (trial >= {1'b0, dvs_q});

        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CNT_W'(DATA_WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = fits ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], fits};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Multi-cycle MULT/DIV with valid/ready handshake and flush abort; MF*/MT* complete in one cycle.
module mult_div_unit
    import mips_core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            md_ctl,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int unsigned CNT_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    md_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  sgn_q, sgn_d;

    md_ctl_e               op;
    logic                  accept;
    logic                  op_signed;
    logic [DATA_WIDTH-1:0] mag1, mag2;
    logic [PROD_W-1:0]     a_ext, b_ext, product;
    logic                  neg_quo, neg_rem;
    logic [DATA_WIDTH-1:0] quo_fix, rem_fix;

    logic                  div_start;
    logic                  div_abort;
    logic                  div_busy;
    logic [DATA_WIDTH-1:0] div_quo, div_rem;

    assign op        = md_decode(md_ctl);
    assign accept    = in_valid & (state_q == IDLE) & ~flush;
    assign op_signed = (op == MULT) || (op == DIV);

    // Divider works on magnitudes; signs are restored in the final fix-up cycle.
    assign mag1 = (op_signed && op1[DATA_WIDTH-1]) ? (DATA_WIDTH'(0) - op1) : op1;
    assign mag2 = (op_signed && op2[DATA_WIDTH-1]) ? (DATA_WIDTH'(0) - op2) : op2;

    // Sign-extending to the full product width gives the signed product modulo 2^PROD_W.
    assign a_ext   = sgn_q ? {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q} : {DATA_WIDTH'(0), a_q};
    assign b_ext   = sgn_q ? {{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q} : {DATA_WIDTH'(0), b_q};
    assign product = a_ext * b_ext;

    assign neg_quo = sgn_q & (a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1]);
    assign neg_rem = sgn_q & a_q[DATA_WIDTH-1];
    assign quo_fix = neg_quo ? (DATA_WIDTH'(0) - div_quo) : div_quo;
    assign rem_fix = neg_rem ? (DATA_WIDTH'(0) - div_rem) : div_rem;

    md_divider #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (mag1),
        .divisor  (mag2),
        .busy     (div_busy),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Next state, HI/LO update and output pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        sgn_d       = sgn_q;
        div_start   = 1'b0;
        div_abort   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        MULT, MULTU: begin
                            a_d     = op1;
                            b_d     = op2;
                            sgn_d   = op_signed;
                            cnt_d   = CNT_W'(MUL_LATENCY - 1);
                            state_d = MUL_BUSY;
                        end
                        DIV, DIVU: begin
                            a_d       = op1;
                            b_d       = op2;
                            sgn_d     = op_signed;
                            div_start = 1'b1;
                            state_d   = DIV_BUSY;
                        end
                        MFHI: begin
                            result_d    = hi_q;
                            out_valid_d = 1'b1;
                        end
                        MFLO: begin
                            result_d    = lo_q;
                            out_valid_d = 1'b1;
                        end
                        MTHI: begin
                            hi_d   = op1;
                            done_d = 1'b1;
                        end
                        MTLO: begin
                            lo_d   = op1;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            // Completion is checked before flush so a flush on the final edge loses.
            MUL_BUSY: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else if (flush) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_BUSY: begin
                if (!div_busy) begin
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (flush) begin
                    div_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sgn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sgn_q       <= sgn_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
